// File: rtl/pri_irq_collector_pkg.sv
// Shared types and sizes for the priority interrupt collector.
package pri_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {IDLE, GRANT} pri_state_t;

    typedef logic [N_REQ-1:0] pri_vec_t;

endpackage

// File: rtl/pri_irq_collector_pick8.sv
// Combinational 8-to-3 priority picker: highest set bit wins.
module pri_pick8
    import pri_pkg::*;
(
    input  pri_vec_t               vec,
    output logic [IDX_W-1:0]       idx_c,
    output logic                   any_c
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_c = '0;
        any_c = |vec;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pri_irq_collector.sv
// Sticky 8-line request collector with handshaked highest-index grant.
// Optional per-line arbitration mask enabled by defining PRI_IRQ_MASK_EN.
module pri_irq_collector
    import pri_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_in,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    input  logic               out_ready,
    output logic [N_REQ-1:0]   pending,
    output logic               overflow
`ifdef PRI_IRQ_MASK_EN
    ,
    input  logic [N_REQ-1:0]   irq_mask
`endif
);

    pri_state_t        state;
    pri_state_t        state_nxt;
    pri_vec_t          req_q;
    pri_vec_t          evt;
    pri_vec_t          clr_vec;
    pri_vec_t          mask;
    pri_vec_t          pending_nxt;
    logic              overflow_nxt;
    logic              valid_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

`ifdef PRI_IRQ_MASK_EN
    assign mask = irq_mask;
`else
    assign mask = '0;
`endif

    pri_pick8 u_pick (
        .vec   (pending & ~mask),
        .idx_c (pick_idx),
        .any_c (pick_any)
    );

    // Capture and pending update; a set in the same cycle as a clear wins.
    always_comb begin
        evt     = EDGE_MODE ? (req_in & ~req_q) : req_in;
        clr_vec = '0;
        if (state == GRANT && out_ready) begin
            clr_vec[out_idx] = 1'b1;
        end
        pending_nxt  = (pending & ~clr_vec) | evt;
        overflow_nxt = |(evt & pending & ~clr_vec);
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        idx_nxt   = out_idx;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_in;
            pending   <= pending_nxt;
            overflow  <= overflow_nxt;
            out_valid <= valid_nxt;
            out_idx   <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_pri_irq_collector.sv
// Directed bench for pri_irq_collector with a queue of expected grant indices.
module tb_pri_irq_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;
    logic [7:0] irq_mask;

    logic [2:0] sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pri_irq_collector #(.EDGE_MODE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
`ifdef PRI_IRQ_MASK_EN
        ,
        .irq_mask  (irq_mask)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [2:0] exp;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed grant idx 0x%0h expected empty scoreboard entry", tag, out_idx);
        end
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            check({tag, "_idx"}, 8'(out_idx), 8'(exp));
        end
    endtask

    // Wait (bounded) for a grant, score it, then handshake for one cycle.
    task automatic take_grant(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 8'(out_valid), 8'h01);
        pop_check(tag);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check({tag, "_drop"}, 8'(out_valid), 8'h00);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_in    = 8'hFF;
        out_ready = 1'b0;
        irq_mask  = 8'h00;

        // Reset with all lines high
        tick(2);
        check("rst_valid",    8'(out_valid), 8'h00);
        check("rst_pending",  pending,       8'h00);
        check("rst_overflow", 8'(overflow),  8'h00);
        req_in = 8'h00;
        rst_n  = 1'b1;
        tick(1);

        // Single event, two-edge latency
        req_in = 8'h20;
        sb.push_back(3'd5);
        tick(1);
        check("single_pend", pending,       8'h20);
        check("single_lat1", 8'(out_valid), 8'h00);
        tick(1);
        check("single_lat2", 8'(out_valid), 8'h01);
        take_grant("single");
        check("single_clr", pending, 8'h00);
        req_in = 8'h00;

        // Ready while idle is ignored; idx holds last value
        out_ready = 1'b1;
        tick(2);
        check("idle_valid", 8'(out_valid), 8'h00);
        check("idle_pend",  pending,       8'h00);
        check("idle_idx",   8'(out_idx),   8'h05);
        out_ready = 1'b0;

        // Priority: 7 then 0, ready held high, two cycles apart
        req_in = 8'h81;
        sb.push_back(3'd7);
        sb.push_back(3'd0);
        out_ready = 1'b1;
        tick(1);
        check("pri_pend", pending, 8'h81);
        tick(1);
        check("pri_v7", 8'(out_valid), 8'h01);
        pop_check("pri_g7");
        tick(1);
        check("pri_bubble", 8'(out_valid), 8'h00);
        check("pri_pend1",  pending,       8'h01);
        tick(1);
        check("pri_v0", 8'(out_valid), 8'h01);
        pop_check("pri_g0");
        tick(1);
        check("pri_done", 8'(out_valid), 8'h00);
        check("pri_pend0", pending, 8'h00);
        out_ready = 1'b0;
        req_in    = 8'h00;
        tick(1);

        // Stability: no preemption while granted
        req_in = 8'h04;
        sb.push_back(3'd2);
        tick(2);
        req_in = 8'h44;
        sb.push_back(3'd6);
        tick(1);
        check("stab_idx1",  8'(out_idx), 8'h02);
        check("stab_pend",  pending,     8'h44);
        req_in = 8'h04;
        tick(1);
        check("stab_idx2",  8'(out_idx), 8'h02);
        take_grant("stab_a");
        take_grant("stab_b");
        req_in = 8'h00;
        tick(1);

        // Overflow and set-beats-clear collision
        req_in = 8'h08;
        sb.push_back(3'd3);
        tick(1);
        check("ovf_first", 8'(overflow), 8'h00);
        req_in = 8'h00;
        tick(1);
        req_in = 8'h08;
        tick(1);
        check("ovf_pulse", 8'(overflow), 8'h01);
        req_in = 8'h00;
        tick(1);
        check("ovf_end", 8'(overflow), 8'h00);
        pop_check("ovf_g3");
        req_in    = 8'h08;
        out_ready = 1'b1;
        tick(1);
        check("coll_pend",  pending,       8'h08);
        check("coll_ovf",   8'(overflow),  8'h00);
        check("coll_valid", 8'(out_valid), 8'h00);
        out_ready = 1'b0;
        req_in    = 8'h00;
        sb.push_back(3'd3);
        take_grant("regrant");
        check("regrant_pend", pending, 8'h00);

`ifdef PRI_IRQ_MASK_EN
        // Masked line captures but waits for unmask
        irq_mask = 8'h80;
        req_in   = 8'h90;
        sb.push_back(3'd4);
        take_grant("mask_g4");
        req_in = 8'h00;
        tick(3);
        check("mask_hold_valid", 8'(out_valid), 8'h00);
        check("mask_hold_pend",  pending,       8'h80);
        irq_mask = 8'h00;
        sb.push_back(3'd7);
        take_grant("mask_g7");
`endif

        // Line held high across reset exit counts as one edge
        rst_n  = 1'b0;
        req_in = 8'h01;
        tick(1);
        check("rstx_pend0", pending, 8'h00);
        rst_n = 1'b1;
        sb.push_back(3'd0);
        tick(1);
        check("rstx_pend1", pending, 8'h01);
        take_grant("rstx");
        check("rstx_clr", pending, 8'h00);

        check("sb_empty", 8'(sb.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
